// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path constants and the buffered fetch entry.
// Imported by the fetch controller and its instruction buffer.
package rv_fetch_pkg;

  localparam int          ADDR_W          = 11;
  localparam int          INSTR_W         = 32;
  localparam int unsigned RESET_PC        = 0;
  localparam int          PC_STEP         = 4;
  localparam int          FETCH_BUF_DEPTH = 2;
  localparam int          OCC_W           = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry fetch buffer: head at slot 0, flush beats push/pop.
// Push and pop in one cycle keep occupancy and order.
module ifetch_buf
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_W  = rv_fetch_pkg::ADDR_W,
  parameter int INSTR_W = rv_fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [OCC_W-1:0]   occ
);

  logic [INSTR_W-1:0] instr_q [FETCH_BUF_DEPTH];
  logic [ADDR_W-1:0]  pc_q    [FETCH_BUF_DEPTH];
  logic [OCC_W-1:0]   occ_q;
  logic               pop_ok;
  logic               full;

  assign head_valid = occ_q != '0;
  assign full       = occ_q == OCC_W'(FETCH_BUF_DEPTH);
  assign pop_ok     = pop & head_valid;
  assign head_instr = instr_q[0];
  assign head_pc    = pc_q[0];
  assign occ        = occ_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (!full) begin
            instr_q[occ_q[0]] <= push_instr;
            pc_q[occ_q[0]]    <= push_pc;
            occ_q             <= occ_q + OCC_W'(1);
          end
        end
        2'b01: begin
          instr_q[0] <= instr_q[1];
          pc_q[0]    <= pc_q[1];
          occ_q      <= occ_q - OCC_W'(1);
        end
        2'b11: begin
          // new word lands behind whatever survives the pop
          if (full) begin
            instr_q[0] <= instr_q[1];
            pc_q[0]    <= pc_q[1];
            instr_q[1] <= push_instr;
            pc_q[1]    <= push_pc;
          end else begin
            instr_q[0] <= push_instr;
            pc_q[0]    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem read per cycle
// under a buffer credit check and handles redirect flushes.
module ifetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int          ADDR_W   = rv_fetch_pkg::ADDR_W,
  parameter int          INSTR_W  = rv_fetch_pkg::INSTR_W,
  parameter int unsigned RESET_PC = rv_fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_rd_addr,
  input  logic [INSTR_W-1:0] imem_rd_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam int                CRD_W = OCC_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [ADDR_W-1:0] redirect_base;
  logic              inflight_q;
  logic              kill_q;
  logic              pop;
  logic              push;
  logic              credit_ok;
  logic [OCC_W-1:0]  occ;
  logic [CRD_W-1:0]  in_use;
  logic              unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign redirect_base  = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = inflight_q & ~kill_q & ~redirect_valid;

  // slots promised after this edge; pop never fires with occ=0
  assign in_use    = CRD_W'(occ) + CRD_W'(inflight_q) - CRD_W'(pop);
  assign credit_ok = in_use < CRD_W'(FETCH_BUF_DEPTH);

  always_comb begin
    imem_rd_en   = 1'b0;
    imem_rd_addr = '0;
    if (!rst) begin
      imem_rd_en   = fetch_en & (redirect_valid | credit_ok);
      imem_rd_addr = redirect_valid ? redirect_base : pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      inflight_q <= imem_rd_en;
      // a redirect reissues at its own target, so the next
      // response is never stale; same-cycle drops use push
      kill_q     <= 1'b0;
      if (imem_rd_en) begin
        inflight_pc_q <= imem_rd_addr;
      end
      if (redirect_valid) begin
        pc_q <= fetch_en ? redirect_base + STEP : redirect_base;
      end else if (imem_rd_en) begin
        pc_q <= pc_q + STEP;
      end
    end
  end

  ifetch_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_instr (imem_rd_instr),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .head_valid (out_valid),
    .head_instr (out_instr),
    .head_pc    (out_pc),
    .occ        (occ)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: per-cycle vector table plus an
// in-order scoreboard of the instruction stream seen by decode.
module tb_ifetch_ctrl;
  import rv_fetch_pkg::*;

  localparam int AW = ADDR_W;

  typedef struct {
    logic          fe;
    logic          rdy;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          ov;
    logic [AW-1:0] opc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_rd_en;
  logic [AW-1:0] imem_rd_addr;
  logic [31:0]   imem_rd_instr = '0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;

  fetch_entry_t  exp_q[$];
  logic [AW-1:0] exp_next;
  vec_t          tbl[40];

  ifetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_instr  (imem_rd_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return 32'h1000_0000 + (32'(a) >> 2);
  endfunction

  // registered read port, word i holds 0x1000_0000 + i
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_instr <= word(imem_rd_addr);
  end

  function automatic vec_t mk(input int fe, input int rdy,
                              input int rv, input int rpc,
                              input int rd, input int ra,
                              input int ov, input int opc);
    vec_t v;
    v.fe      = 1'(fe);
    v.rdy     = 1'(rdy);
    v.rv      = 1'(rv);
    v.rpc     = AW'(rpc);
    v.rd_en   = 1'(rd);
    v.rd_addr = AW'(ra);
    v.ov      = 1'(ov);
    v.opc     = AW'(opc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // drive one cycle, sample at the falling edge
  task automatic cyc(input int r, input int fe, input int rdy,
                     input int rv, input int rpc);
    fetch_entry_t e;
    @(posedge clk);
    #1;
    rst            = 1'(r);
    fetch_en       = 1'(fe);
    out_ready      = 1'(rdy);
    redirect_valid = 1'(rv);
    redirect_pc    = AW'(rpc);
    if (r != 0) begin
      exp_q.delete();
      exp_next = AW'(RESET_PC);
    end else if (rv != 0) begin
      exp_q.delete();
      exp_next = AW'(rpc) & ~AW'(3);
    end
    while (exp_q.size() < 4) begin
      e.pc    = exp_next;
      e.instr = word(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + AW'(4);
    end
    @(negedge clk);
    if (r == 0 && rv == 0 && out_valid && out_ready) begin
      n_acc++;
      e = exp_q.pop_front();
      chk("sb_pc", 32'(out_pc), 32'(e.pc));
      chk("sb_instr", out_instr, e.instr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exp_next = '0;

    // startup and steady stream
    tbl[0]  = mk(1, 1, 0, 0,     1, 'h000, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0,     1, 'h004, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0,     1, 'h008, 1, 'h000);
    tbl[3]  = mk(1, 1, 0, 0,     1, 'h00c, 1, 'h004);
    tbl[4]  = mk(1, 1, 0, 0,     1, 'h010, 1, 'h008);
    tbl[5]  = mk(1, 1, 0, 0,     1, 'h014, 1, 'h00c);
    // backpressure for 5 cycles
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1, 0, 0, 0,    0, 'h018, 1, 'h010);
    tbl[11] = mk(1, 1, 0, 0,     1, 'h018, 1, 'h010);
    tbl[12] = mk(1, 1, 0, 0,     1, 'h01c, 1, 'h014);
    tbl[13] = mk(1, 1, 0, 0,     1, 'h020, 1, 'h018);
    tbl[14] = mk(1, 1, 0, 0,     1, 'h024, 1, 'h01c);
    // fill buffer, then unaligned redirect
    tbl[15] = mk(1, 0, 0, 0,     0, 'h028, 1, 'h020);
    tbl[16] = mk(1, 0, 0, 0,     0, 'h028, 1, 'h020);
    tbl[17] = mk(1, 1, 1, 'h103, 1, 'h100, 1, 'h020);
    tbl[18] = mk(1, 1, 0, 0,     1, 'h104, 0, 0);
    tbl[19] = mk(1, 1, 0, 0,     1, 'h108, 1, 'h100);
    tbl[20] = mk(1, 1, 0, 0,     1, 'h10c, 1, 'h104);
    // redirect with pop and response colliding; wrap target
    tbl[21] = mk(1, 1, 1, 'h7fc, 1, 'h7fc, 1, 'h108);
    tbl[22] = mk(1, 1, 0, 0,     1, 'h000, 0, 0);
    tbl[23] = mk(1, 1, 0, 0,     1, 'h004, 1, 'h7fc);
    tbl[24] = mk(1, 1, 0, 0,     1, 'h008, 1, 'h000);
    tbl[25] = mk(1, 1, 0, 0,     1, 'h00c, 1, 'h004);
    // back-to-back redirects
    tbl[26] = mk(1, 1, 1, 'h200, 1, 'h200, 1, 'h008);
    tbl[27] = mk(1, 1, 1, 'h300, 1, 'h300, 0, 0);
    tbl[28] = mk(1, 1, 0, 0,     1, 'h304, 0, 0);
    tbl[29] = mk(1, 1, 0, 0,     1, 'h308, 1, 'h300);
    tbl[30] = mk(1, 1, 0, 0,     1, 'h30c, 1, 'h304);
    // redirect while fetch disabled
    tbl[31] = mk(0, 1, 1, 'h400, 0, 'h400, 1, 'h308);
    tbl[32] = mk(0, 1, 0, 0,     0, 'h400, 0, 0);
    tbl[33] = mk(1, 1, 0, 0,     1, 'h400, 0, 0);
    tbl[34] = mk(1, 1, 0, 0,     1, 'h404, 0, 0);
    tbl[35] = mk(1, 1, 0, 0,     1, 'h408, 1, 'h400);
    // fetch_en falls with a read in flight
    tbl[36] = mk(0, 0, 0, 0,     0, 'h40c, 1, 'h404);
    tbl[37] = mk(0, 1, 0, 0,     0, 'h40c, 1, 'h404);
    tbl[38] = mk(0, 1, 0, 0,     0, 'h40c, 1, 'h408);
    tbl[39] = mk(0, 1, 0, 0,     0, 'h40c, 0, 0);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_rd_en", 32'(imem_rd_en), 0);
    chk("rst_rd_addr", 32'(imem_rd_addr), 0);

    for (int i = 0; i < 40; i++) begin
      cyc(0, int'(tbl[i].fe), int'(tbl[i].rdy),
          int'(tbl[i].rv), int'(tbl[i].rpc));
      chk($sformatf("r%0d_rd_en", i), 32'(imem_rd_en),
          32'(tbl[i].rd_en));
      chk($sformatf("r%0d_rd_addr", i), 32'(imem_rd_addr),
          32'(tbl[i].rd_addr));
      chk($sformatf("r%0d_out_valid", i), 32'(out_valid),
          32'(tbl[i].ov));
      if (tbl[i].ov)
        chk($sformatf("r%0d_out_pc", i), 32'(out_pc),
            32'(tbl[i].opc));
    end
    chk("accept_cnt", 32'(n_acc), 18);

    // mid-stream reset with a read outstanding
    cyc(0, 1, 1, 0, 0);
    chk("rs_rd_en", 32'(imem_rd_en), 1);
    chk("rs_rd_addr", 32'(imem_rd_addr), 'h40c);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rs_hold_rd_en", 32'(imem_rd_en), 0);
    cyc(0, 1, 1, 0, 0);
    chk("rs_out_valid", 32'(out_valid), 0);
    chk("rs_out_instr", out_instr, 0);
    chk("rs_out_pc", 32'(out_pc), 0);
    chk("rs_restart_en", 32'(imem_rd_en), 1);
    chk("rs_restart_addr", 32'(imem_rd_addr), RESET_PC);
    cyc(0, 1, 1, 0, 0);
    chk("rs_lat_valid", 32'(out_valid), 0);
    cyc(0, 1, 1, 0, 0);
    chk("rs_first_valid", 32'(out_valid), 1);
    chk("rs_first_pc", 32'(out_pc), RESET_PC);

    // random backpressure: order and completeness via scoreboard
    n0 = n_acc;
    repeat (80) cyc(0, 1, int'($urandom_range(0, 1)), 0, 0);
    repeat (4) cyc(0, 1, 1, 0, 0);
    chk("rand_progress", 32'(n_acc > n0 + 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
